code_arbiter: RTL and testbench
===============================

Name: code_arbiter

Overview:
Round-robin arbiter that shares one 3-bit-to-7-bit code encoder among NUM_REQ requesters. Each requester presents a 3-bit symbol with a request line. The block grants one requester at a time and encodes the granted symbol. The encoded code is presented downstream on a valid/ready output stage, and delivered codes are counted. It sits between symbol producers and the single code output bus.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8
USE_GRAY, 0, encoding table; 0 = one-hot table, 1 = Gray table (see Behaviour)
GAP, 0, idle cycles forced after each delivered code; legal range 0..15

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  request per requester; held high with sym stable until granted
sym  in  3*NUM_REQ  symbol per requester; requester i uses bits [3i+2:3i]
gnt  out  NUM_REQ  one-hot grant, registered, high for exactly one cycle
out_code  out  7  encoded code of the granted symbol, registered
out_src  out  max(1,$clog2(NUM_REQ))  index of the requester that produced out_code
out_valid  out  1  out_code/out_src valid
out_ready  in  1  downstream accepts when out_valid & out_ready at a rising edge
sent_cnt  out  8  number of accepted codes; wraps 255 -> 0

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, gnt=0, out_valid=0, out_code=0, out_src=0, sent_cnt=0, gap counter=0, rr pointer=0 (requester 0 highest priority).
- States: IDLE, SEND, GAP.
- IDLE, with any req bit high at an edge:
  - Winner = first set req bit scanning ptr, ptr+1, ... modulo NUM_REQ.
  - After that edge: gnt[winner]=1, out_code=enc(sym[winner]), out_src=winner, out_valid=1, ptr=(winner+1) mod NUM_REQ, state=SEND.
  - Latency from request to grant and valid output is 1 edge.
- IDLE, with no req at an edge: outputs unchanged, gnt=0.
- gnt is cleared on the edge after it is asserted, regardless of state.
- SEND:
  - out_code, out_src and out_valid are held stable until out_ready=1 at an edge.
  - On that edge: out_valid=0, sent_cnt+=1 (wrapping).
  - Next state is GAP with counter=GAP if GAP>0, else IDLE.
- GAP: counter decrements each edge; at 1 -> IDLE. No grants are issued.
- Requests during SEND or GAP are not granted. Requesters keep req and sym held, and are arbitrated on the first IDLE edge.
- Maximum throughput is 1 code per 2+GAP cycles.
- A requester that keeps req high after its grant is treated as a new request and competes under round-robin.
- Encoding tables (sym 0..7):
  - USE_GRAY=0: 0,1,2,4,8,16,32,64
  - USE_GRAY=1: 0,1,3,2,6,7,5,4
  - sym=0 yields code 0 with out_valid=1; valid, not code value, marks presence.
- out_code bits [6:3] are 0 in Gray mode.
- Simultaneous requests: only one grant per IDLE edge. The rotation guarantees every persistent requester is served within NUM_REQ grants.
- Reset asserted mid-SEND: out_valid and gnt drop immediately (asynchronously). The pending code is discarded and not counted.
- out_ready high while out_valid=0 has no effect.

Decomposition:
- Shared package code_arb_pkg holds:
  - the state enumeration (IDLE, SEND, GAP)
  - code width constant 7
  - symbol width constant 3
- The encoding is one instance of the team's existing 3-bit -> 7-bit encoder module (name: encoder), with USE_GRAY passed through. Its input is the arbiter-muxed winning symbol; its output is registered into out_code on grant.
- Round-robin winner selection is a function in code_arb_pkg. It needs no separate module.

Test Plan:
- Reset then single request (NUM_REQ=4, USE_GRAY=0): req=0010, sym[1]=5, out_ready=1 -> after 1 edge gnt=0010 for one cycle, out_code=16, out_src=1, out_valid=1; next edge out_valid=0, sent_cnt=1.
- Back-pressure: req=0001, sym[0]=7, out_ready=0 for 5 cycles -> out_code=64, out_valid stay stable 5 cycles, no second grant, sent_cnt unchanged; raise out_ready -> accepted, sent_cnt+1.
- Round-robin fairness: req=1111 held continuously, out_ready=1 -> out_src sequence 0,1,2,3,0 with one grant every 2 cycles.
- Gray mode plus GAP=3 (USE_GRAY=1): sym sweep 0..7 on requester 2 -> codes 0,1,3,2,6,7,5,4, consecutive out_valid pulses separated by exactly 4 low cycles.
- Async reset mid-SEND: rst pulsed between edges while out_valid=1 -> out_valid=0, gnt=0 immediately, sent_cnt=0; first grant after reset goes to requester 0 when req=1111.
- Counter wrap: 256 accepted codes -> sent_cnt returns to 0; sym=0 delivers out_code=0 with out_valid=1 and is counted.

Source files
------------

// File: rtl/code_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | code_arb_pkg: shared constants, states and round-robin pick (rev 1.0) |
// +----------------------------------------------------------------------+
package code_arb_pkg;

  localparam int CODE_W = 7;
  localparam int SYM_W  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // First set request scanning ptr, ptr+1, ... modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] win;
    logic       found;
    int         idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i < n) && !found && req[idx]) begin
        win   = 3'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | encoder: 3-bit symbol to 7-bit code, one-hot or Gray table (rev 1.0)  |
// +----------------------------------------------------------------------+
module encoder #(
  parameter int USE_GRAY = 0
) (
  input  logic [2:0] sym,
  output logic [6:0] code
);

  generate
    if (USE_GRAY != 0) begin : g_gray
      always_comb begin
        code = '0;
        case (sym)
          3'd0: code = 7'd0;
          3'd1: code = 7'd1;
          3'd2: code = 7'd3;
          3'd3: code = 7'd2;
          3'd4: code = 7'd6;
          3'd5: code = 7'd7;
          3'd6: code = 7'd5;
          3'd7: code = 7'd4;
          default: code = '0;
        endcase
      end
    end else begin : g_onehot
      // Symbol 0 maps to an all-zero code; 1..7 select a single bit.
      always_comb begin
        code = '0;
        case (sym)
          3'd0: code = 7'd0;
          3'd1: code = 7'd1;
          3'd2: code = 7'd2;
          3'd3: code = 7'd4;
          3'd4: code = 7'd8;
          3'd5: code = 7'd16;
          3'd6: code = 7'd32;
          3'd7: code = 7'd64;
          default: code = '0;
        endcase
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/code_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | code_arbiter: round-robin share of one symbol encoder (rev 1.0)       |
// +----------------------------------------------------------------------+
module code_arbiter
  import code_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int USE_GRAY = 0,
  parameter  int GAP      = 0,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [SYM_W*NUM_REQ-1:0] sym,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [CODE_W-1:0]        out_code,
  output logic [SRC_W-1:0]         out_src,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               sent_cnt
);

  logic [1:0]         state;
  logic [2:0]         ptr;
  logic [3:0]         gap_cnt;
  logic [7:0]         req_ext;
  logic [2:0]         winner;
  logic [2:0]         next_ptr;
  logic [SYM_W-1:0]   win_sym;
  logic [CODE_W-1:0]  win_code;
  logic [NUM_REQ-1:0] win_onehot;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
  end

  assign winner   = rr_pick(req_ext, ptr, NUM_REQ);
  assign next_ptr = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
  assign win_sym  = sym[SYM_W*int'(winner) +: SYM_W];

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_onehot[i] = (winner == 3'(i));
    end
  end

  encoder #(.USE_GRAY(USE_GRAY)) u_encoder (
    .sym  (win_sym),
    .code (win_code)
  );

  // gnt defaults low every cycle so it is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      out_code  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      gnt <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt       <= win_onehot;
            out_code  <= win_code;
            out_src   <= winner[SRC_W-1:0];
            out_valid <= 1'b1;
            ptr       <= next_ptr;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sent_cnt  <= sent_cnt + 8'd1;
            if (GAP > 0) begin
              gap_cnt <= 4'(GAP);
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_code_arbiter: scoreboard bench for code_arbiter (rev 1.0)          |
// +----------------------------------------------------------------------+
module tb_code_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut a: one-hot table, no gap; dut b: Gray table, GAP=3
  logic [3:0]  req_a, gnt_a, req_b, gnt_b;
  logic [11:0] sym_a, sym_b;
  logic        ready_a, valid_a, ready_b, valid_b;
  logic [6:0]  code_a, code_b;
  logic [1:0]  src_a, src_b;
  logic [7:0]  cnt_a, cnt_b;

  code_arbiter #(.NUM_REQ(4), .USE_GRAY(0), .GAP(0)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .sym(sym_a), .gnt(gnt_a),
    .out_code(code_a), .out_src(src_a), .out_valid(valid_a),
    .out_ready(ready_a), .sent_cnt(cnt_a)
  );

  code_arbiter #(.NUM_REQ(4), .USE_GRAY(1), .GAP(3)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .sym(sym_b), .gnt(gnt_b),
    .out_code(code_b), .out_src(src_b), .out_valid(valid_b),
    .out_ready(ready_b), .sent_cnt(cnt_b)
  );

  typedef struct packed {
    logic [6:0] code;
    logic [1:0] src;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t mk(input logic [6:0] code, input logic [1:0] src);
    exp_t e;
    e.code = code;
    e.src  = src;
    return e;
  endfunction

  // Every grant pulse pops one expected code/source.
  always @(negedge clk) begin
    if (!rst && gnt_a != 4'd0) begin
      exp_t e;
      n_tests++;
      if (q_a.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a: unexpected grant gnt=%b code=%0d src=%0d, required none", gnt_a, code_a, src_a);
      end else begin
        e = q_a.pop_front();
        if (code_a !== e.code || src_a !== e.src || gnt_a !== (4'd1 << e.src) || valid_a !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_a: got code=%0d src=%0d gnt=%b valid=%b, required code=%0d src=%0d valid=1",
                   code_a, src_a, gnt_a, valid_a, e.code, e.src);
        end
      end
    end
    if (!rst && gnt_b != 4'd0) begin
      exp_t e;
      n_tests++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b: unexpected grant gnt=%b code=%0d src=%0d, required none", gnt_b, code_b, src_b);
      end else begin
        e = q_b.pop_front();
        if (code_b !== e.code || src_b !== e.src || gnt_b !== (4'd1 << e.src) || valid_b !== 1'b1) begin
          n_fail++;
          $display("FAIL sb_b: got code=%0d src=%0d gnt=%b valid=%b, required code=%0d src=%0d valid=1",
                   code_b, src_b, gnt_b, valid_b, e.code, e.src);
        end
      end
    end
  end

  // Waits (bounded) for a grant to idx; reports negedges waited and valid-low negedges seen.
  task automatic wait_gnt(input bit b, input int idx, output int cycles, output int lows);
    cycles = 0;
    lows   = 0;
    n_tests++;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      cycles++;
      if ((b ? valid_b : valid_a) == 1'b0) lows++;
      if (b ? gnt_b[idx] : gnt_a[idx]) return;
    end
    n_fail++;
    $display("FAIL wait_gnt: dut %0d got no grant to %0d within 60 cycles, required one", b, idx);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_tests++;
    if (gnt_a !== 4'd0 || valid_a !== 1'b0 || code_a !== 7'd0 || src_a !== 2'd0 || cnt_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_a: gnt=%b valid=%b code=%0d src=%0d cnt=%0d, required all 0", gnt_a, valid_a, code_a, src_a, cnt_a);
    end
    n_tests++;
    if (gnt_b !== 4'd0 || valid_b !== 1'b0 || code_b !== 7'd0 || src_b !== 2'd0 || cnt_b !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_b: gnt=%b valid=%b code=%0d src=%0d cnt=%0d, required all 0", gnt_b, valid_b, code_b, src_b, cnt_b);
    end
    rst     = 1'b0;
    ready_a = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cnt_a !== 8'd0 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: cnt=%0d valid=%b, required cnt=0 valid=0", cnt_a, valid_a);
    end
  endtask

  task automatic test_single;
    int c, l;
    q_a.push_back(mk(7'd16, 2'd1));
    sym_a[5:3] = 3'd5;
    req_a      = 4'b0010;
    ready_a    = 1'b1;
    wait_gnt(0, 1, c, l);
    req_a = 4'b0000;
    n_tests++;
    if (c !== 1 || valid_a !== 1'b1 || code_a !== 7'd16 || src_a !== 2'd1) begin
      n_fail++;
      $display("FAIL single: latency=%0d valid=%b code=%0d src=%0d, required 1/1/16/1", c, valid_a, code_a, src_a);
    end
    @(negedge clk);
    n_tests++;
    if (valid_a !== 1'b0 || cnt_a !== 8'd1 || gnt_a !== 4'd0) begin
      n_fail++;
      $display("FAIL single_accept: valid=%b cnt=%0d gnt=%b, required 0/1/0000", valid_a, cnt_a, gnt_a);
    end
  endtask

  task automatic test_backpressure;
    int c, l;
    ready_a    = 1'b0;
    sym_a[2:0] = 3'd7;
    req_a      = 4'b0001;
    q_a.push_back(mk(7'd64, 2'd0));
    wait_gnt(0, 0, c, l);
    req_a      = 4'b0100;
    sym_a[8:6] = 3'd3;
    q_a.push_back(mk(7'd4, 2'd2));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (valid_a !== 1'b1 || code_a !== 7'd64 || src_a !== 2'd0 || gnt_a !== 4'd0 || cnt_a !== 8'd1) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b code=%0d src=%0d gnt=%b cnt=%0d, required 1/64/0/0000/1",
                 k, valid_a, code_a, src_a, gnt_a, cnt_a);
      end
    end
    ready_a = 1'b1;
    @(negedge clk);
    n_tests++;
    if (valid_a !== 1'b0 || cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b cnt=%0d, required 0/2", valid_a, cnt_a);
    end
    wait_gnt(0, 2, c, l);
    req_a = 4'b0000;
    n_tests++;
    if (c !== 1) begin
      n_fail++;
      $display("FAIL bp_pending: waited=%0d cycles, required 1", c);
    end
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 8'd3 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: cnt=%0d valid=%b, required 3/0", cnt_a, valid_a);
    end
  endtask

  task automatic test_async_reset;
    int c, l;
    ready_a    = 1'b0;
    sym_a[2:0] = 3'd2;
    req_a      = 4'b0001;
    q_a.push_back(mk(7'd2, 2'd0));
    wait_gnt(0, 0, c, l);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (gnt_a !== 4'd0 || valid_a !== 1'b0 || cnt_a !== 8'd0 || code_a !== 7'd0) begin
      n_fail++;
      $display("FAIL async_rst: gnt=%b valid=%b cnt=%0d code=%0d, required 0000/0/0/0", gnt_a, valid_a, cnt_a, code_a);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    int c, l;
    sym_a = {3'd4, 3'd3, 3'd2, 3'd1};
    q_a.push_back(mk(7'd1, 2'd0));
    q_a.push_back(mk(7'd2, 2'd1));
    q_a.push_back(mk(7'd4, 2'd2));
    q_a.push_back(mk(7'd8, 2'd3));
    q_a.push_back(mk(7'd1, 2'd0));
    ready_a = 1'b1;
    req_a   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(0, k % 4, c, l);
      n_tests++;
      if (c !== ((k == 0) ? 1 : 2)) begin
        n_fail++;
        $display("FAIL rr_spacing[%0d]: %0d cycles, required %0d", k, c, (k == 0) ? 1 : 2);
      end
    end
    req_a = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 8'd5 || valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_count: cnt=%0d valid=%b, required 5/0", cnt_a, valid_a);
    end
  endtask

  task automatic test_counter_wrap;
    int c, l;
    sym_a[2:0] = 3'd0;
    ready_a    = 1'b1;
    for (int k = 0; k < 256; k++) q_a.push_back(mk(7'd0, 2'd0));
    req_a = 4'b0001;
    for (int k = 0; k < 256; k++) begin
      wait_gnt(0, 0, c, l);
      if (k == 250) begin
        n_tests++;
        if (cnt_a !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: cnt=%0d, required 255", cnt_a);
        end
      end
      if (k == 251) begin
        n_tests++;
        if (cnt_a !== 8'd0 || valid_a !== 1'b1 || code_a !== 7'd0) begin
          n_fail++;
          $display("FAIL wrap_0: cnt=%0d valid=%b code=%0d, required 0/1/0", cnt_a, valid_a, code_a);
        end
      end
    end
    req_a = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (cnt_a !== 8'd5) begin
      n_fail++;
      $display("FAIL wrap_end: cnt=%0d, required 5", cnt_a);
    end
  endtask

  task automatic test_gray_gap;
    int c, l;
    logic [6:0] gray_tab [8];
    gray_tab = '{7'd0, 7'd1, 7'd3, 7'd2, 7'd6, 7'd7, 7'd5, 7'd4};
    for (int s = 0; s < 8; s++) q_b.push_back(mk(gray_tab[s], 2'd2));
    ready_b = 1'b1;
    req_b   = 4'b0100;
    for (int s = 0; s < 8; s++) begin
      sym_b[8:6] = 3'(s);
      wait_gnt(1, 2, c, l);
      if (s > 0) begin
        n_tests++;
        if (l !== 4 || c !== 5) begin
          n_fail++;
          $display("FAIL gray_gap[%0d]: low=%0d period=%0d, required 4/5", s, l, c);
        end
      end
    end
    req_b = 4'b0000;
    @(negedge clk);
    n_tests++;
    if (cnt_b !== 8'd8 || valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL gray_count: cnt=%0d valid=%b, required 8/0", cnt_b, valid_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_a = '0; sym_a = '0; ready_a = 1'b0;
    req_b = '0; sym_b = '0; ready_b = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_async_reset();
    test_round_robin();
    test_counter_wrap();
    test_gray_gap();
    repeat (2) @(negedge clk);
    n_tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d/%0d codes never delivered, required 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
